// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, word-address LSB and the completer FSM state type.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int ADDR_LSB   = 2;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter holding the remaining wait states of the current APB transfer.
module apb_wait_ctr #(
    parameter int WAIT_W = 4
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);

    logic [WAIT_W-1:0] r_cnt;

    // A fresh setup always wins over a decrement.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= load_val_i;
        end else if (dec_i && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer backing a word-addressed register file, with a per-transfer
// programmable number of wait states sampled in the setup phase.
//
// state  | meaning
// IDLE   | no transfer in flight, waiting for a setup phase
// ACCESS | transfer captured; counting wait states, completes when counter hits 0
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DATA_W   = APB_DATA_W,
    parameter int ADDR_W   = APB_ADDR_W,
    parameter int NUM_REGS = 16,
    parameter int WAIT_W   = 4
) (
    input  logic              pclk_i,
    input  logic              prst_i,
    input  logic              psel_i,
    input  logic              penable_i,
    input  logic [ADDR_W-1:0] paddr_i,
    input  logic              pwrite_i,
    input  logic [DATA_W-1:0] pwdata_i,
    input  logic [WAIT_W-1:0] wait_cfg_i,
    output logic [DATA_W-1:0] prdata_o,
    output logic              pready_o,
    output logic              pslverr_o
);

    localparam int                IDX_W      = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);

    apb_slv_state_e    r_state;
    logic [IDX_W-1:0]  r_idx;
    logic              r_write;
    logic              r_err;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_setup;
    logic              w_access;
    logic              w_zero;
    logic              w_complete;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;

    assign w_setup    = psel_i & ~penable_i;
    assign w_access   = (r_state == ACCESS) & psel_i & penable_i;
    assign w_complete = w_access & w_zero;
    assign w_idx      = paddr_i[ADDR_LSB +: IDX_W];
    assign w_err      = (paddr_i[ADDR_LSB-1:0] != '0) | (paddr_i >= ADDR_LIMIT);

    apb_wait_ctr #(
        .WAIT_W (WAIT_W)
    ) u_wait_ctr (
        .pclk_i     (pclk_i),
        .prst_i     (prst_i),
        .load_i     (w_setup),
        .load_val_i (wait_cfg_i),
        .dec_i      (w_access & ~w_zero),
        .zero_o     (w_zero)
    );

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_setup) r_state <= ACCESS;
                end
                ACCESS: begin
                    if (!psel_i || w_complete) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A setup seen while in ACCESS is a protocol violation; it simply restarts the transfer.
    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            r_idx   <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_setup) begin
            r_idx   <= w_idx;
            r_write <= pwrite_i;
            r_err   <= w_err;
            r_wdata <= pwdata_i;
            r_rdata <= r_regs[w_idx];
        end
    end

    always_ff @(posedge pclk_i or posedge prst_i) begin
        if (prst_i) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_complete && r_write && !r_err) begin
            r_regs[r_idx] <= r_wdata;
        end
    end

    assign pready_o  = w_complete;
    assign pslverr_o = w_complete & r_err;
    assign prdata_o  = (w_complete & ~r_write & ~r_err) ? r_rdata : '0;

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB3 completer that sits directly downstream of the APB master.
- Consumes psel/penable/paddr/pwrite/pwdata and returns prdata/pready/pslverr.
- Backs a small word-addressed register file.
- Inserts a programmable number of wait states per transfer, so the master's wait-state handling can run against real hardware rather than a bench model.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 32, address bus width.
- NUM_REGS, 16, number of 32-bit registers, power of two, at least 2.
- WAIT_W, 4, width of the wait-state configuration input.

Ports:
- pclk_i  in  1  APB clock; all state updates on the rising edge.
- prst_i  in  1  asynchronous, active-high reset.
- psel_i  in  1  slave select from the master.
- penable_i  in  1  access-phase indicator.
- paddr_i  in  ADDR_W  byte address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  DATA_W  write data.
- wait_cfg_i  in  WAIT_W  wait states per transfer; sampled in the setup phase.
- prdata_o  out  DATA_W  read data; valid only while pready_o=1 on a read.
- pready_o  out  1  transfer-complete indication.
- pslverr_o  out  1  error response; valid only while pready_o=1.

Behaviour:
- Clock and reset: one clock, pclk_i. Reset prst_i is asynchronous and active-high.
- Reset values:
  - state IDLE, wait counter 0.
  - all registers 0, captured address/write/data 0.
  - prdata_o=0, pready_o=0, pslverr_o=0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel_i=1 and penable_i=0 (setup phase): capture paddr_i, pwrite_i, pwdata_i; load counter with wait_cfg_i; compute the error flag; latch read data regs[idx]; next state ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - If psel_i=0: abort. Return to IDLE, no write, no response.
  - If psel_i=1, penable_i=1 and counter>0: decrement the counter.
  - If psel_i=1, penable_i=1 and counter==0: complete the transfer. On a write with no error, regs[idx] takes the captured data at this edge. Next state IDLE.
  - If psel_i=1 and penable_i=0: protocol violation. Treat it as a new setup: recapture everything and stay in ACCESS.
- Outputs (all combinational from registered state):
  - pready_o = ACCESS & psel_i & penable_i & (counter==0).
  - pslverr_o = pready_o & err_q.
  - prdata_o = (pready_o & ~write_q & ~err_q) ? rdata_q : 0.
- Latency:
  - Access phase lasts wait_cfg_i+1 cycles.
  - With wait_cfg_i=0, pready_o is high in the first access cycle, giving a zero-wait APB transfer of 2 cycles total.
- Back-to-back: a setup phase in the cycle right after completion is accepted from IDLE with no bubble.
- Address decode:
  - idx = paddr_i[2 +: log2(NUM_REGS)].
  - err is set when paddr_i[1:0]!=0 or paddr_i >= NUM_REGS*4.
  - An error write leaves all registers unchanged. An error read returns 0.
- Write then read of the same register: the read setup follows the write completion edge, so it returns the new value.
- wait_cfg_i changes mid-transfer have no effect; only the value sampled at setup counts.
- Reset asserted mid-transfer: immediate return to the reset values. The interrupted write does not commit.

Decomposition:
- Shared package apb_pkg holds:
  - typedef enum apb_slv_state_e {IDLE, ACCESS}.
  - localparam ADDR_LSB=2.
  - default DATA_W/ADDR_W constants (reusable by the APB master).
- One natural sub-module: apb_wait_ctr, a loadable down-counter with load, dec and zero outputs, width WAIT_W.
- FSM, decode and register array stay in the top.

Test Plan:
- Write 0xDEADBEEF to addr 0x04 with wait_cfg=0, then read 0x04 -> pready high in the first access cycle both times, prdata=0xDEADBEEF, pslverr=0.
- wait_cfg=3, read addr 0x08 after writing 0x12345678 -> pready low for exactly 3 access cycles, high on the 4th, prdata=0x12345678.
- Write 0xFFFFFFFF to 0x40 (out of range) and to 0x05 (misaligned) -> pready with pslverr=1; then reading 0x3C returns its prior value, and reading 0x40 returns prdata=0.
- Back-to-back: write 0xA5A5A5A5 to 0x0C, and in the next cycle issue a read setup to 0x0C -> no idle bubble required, read returns 0xA5A5A5A5.
- Abort: with wait_cfg=2, deassert psel during the second access cycle of a write of 0x1111 to 0x10 -> no pready, reg 0x10 unchanged (0), FSM back in IDLE.
- Reset mid-access: assert prst_i during a wait state of a write to 0x00 -> pready_o=0 immediately, and after release reading 0x00 returns 0.
